// File: rtl/control_unit.sv
// control_unit: multicycle Moore FSM sequencing the CPU datapath (PC/EPC,
// memory, IR, register bank, A/B, ALUOut, MDR, HI/LO, multiplier).
// Decodes OPCODE/FUNCT and drives every write enable and mux select.
// Supports add/sub/and, mult, mfhi/mflo, addi, lw, sw, beq, bne, j; traps on
// invalid opcode/funct and on ALU overflow through the exception vector table.
//
// Ports:
//   clk, reset (async, active-high)
//   OPCODE, FUNCT        IR fields
//   OVERFLOW, ZERO       ALU flags (combinational)
//   mult_end             multiplier done
//   *_w, mult_control    write enables / mult start pulse
//   Mux_*, ALUOp, LS_control, SS_control   datapath selects
//   state                current state code (debug)
//
// state     | meaning
// ----------+---------------------------------------------------
// RESET     | held in reset, all outputs 0 (encoded as 0)
// FETCH1    | present PC to memory, ALUOut <= PC+4
// FETCHW    | memory wait (MEM_WAIT cycles)
// FETCH3    | IR <= mem, PC <= PC+4
// DECODE    | A/B <= regs, ALUOut <= branch target, dispatch
// R_EX/R_WB | R-type execute / write back to rd
// ADDI_*    | addi execute / write back to rt
// MULT      | one-cycle multiplier start
// MULT_W    | wait for mult_end
// MULT_END  | HI/LO <= product
// MFHL      | rd <= HI or LO
// ADDR      | ALUOut <= A + imm (effective address)
// SW        | memory write
// LD1/LDW   | present load address / memory wait
// LD3/LD_WB | MDR <= mem / rt <= MDR
// BR        | beq/bne resolution
// JUMP      | PC <= jump target
// EXC1      | ALUOut <= PC-4, latch exception code
// EXC2/EXCW | EPC <= ALUOut, read vector byte / memory wait
// EXC4      | PC <= vector

module control_unit #(
    parameter int         MEM_WAIT    = 1,
    parameter logic [1:0] EXC_OP_SEL  = 2'd0,
    parameter logic [1:0] EXC_OVF_SEL = 2'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       OVERFLOW,
    input  logic       ZERO,
    input  logic       mult_end,
    output logic       PC_w,
    output logic       PC_w_cond,
    output logic       EPC_w,
    output logic       MEM_w,
    output logic       IR_w,
    output logic       ALUOut_w,
    output logic       RB_w,
    output logic       A_w,
    output logic       B_w,
    output logic       HI_w,
    output logic       LO_w,
    output logic       MEM_DATA_REG_w,
    output logic       mult_control,
    output logic [1:0] Mux_PC,
    output logic [1:0] Mux_MEM,
    output logic [1:0] Mux_EXC,
    output logic [1:0] Mux_W_RB,
    output logic [2:0] Mux_W_DT,
    output logic [1:0] Mux_ALUSrcA,
    output logic [1:0] Mux_ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] LS_control,
    output logic [1:0] SS_control,
    output logic [5:0] state
);

    localparam logic [5:0] S_RESET   = 6'd0,  S_FETCH1  = 6'd1,  S_FETCHW  = 6'd2,
                           S_FETCH3  = 6'd3,  S_DECODE  = 6'd4,  S_R_EX    = 6'd5,
                           S_R_WB    = 6'd6,  S_ADDI_EX = 6'd7,  S_ADDI_WB = 6'd8,
                           S_MULT    = 6'd9,  S_MULT_W  = 6'd10, S_MULT_END= 6'd11,
                           S_MFHL    = 6'd12, S_ADDR    = 6'd13, S_SW      = 6'd14,
                           S_LD1     = 6'd15, S_LDW     = 6'd16, S_LD3     = 6'd17,
                           S_LD_WB   = 6'd18, S_BR      = 6'd19, S_JUMP    = 6'd20,
                           S_EXC1    = 6'd21, S_EXC2    = 6'd22, S_EXCW    = 6'd23,
                           S_EXC4    = 6'd24;

    localparam int              CNT_W     = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT);

    logic [5:0]       next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       exc_code;
    logic             wait_done;
    logic             next_is_wait;
    logic [3:0]       r_alu_op;

    assign wait_done    = (wait_cnt <= CNT_W'(1));
    assign next_is_wait = (next_state == S_FETCHW) || (next_state == S_LDW) ||
                          (next_state == S_EXCW);
    assign r_alu_op     = (FUNCT == 6'h22) ? 4'd2 : (FUNCT == 6'h24) ? 4'd3 : 4'd1;

    // State register, wait down-counter and exception-code latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_RESET;
            wait_cnt <= '0;
            exc_code <= 2'd0;
        end else begin
            state <= next_state;
            // reload only on entry so each wait sequence lasts exactly MEM_WAIT cycles
            if (next_is_wait && (next_state != state))
                wait_cnt <= WAIT_LOAD;
            else if (wait_cnt != '0)
                wait_cnt <= wait_cnt - CNT_W'(1);
            // only DECODE traps on an invalid encoding; every other entry is overflow
            if (next_state == S_EXC1 && state != S_EXC1)
                exc_code <= (state == S_DECODE) ? EXC_OP_SEL : EXC_OVF_SEL;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_RESET:    next_state = S_FETCH1;
            S_FETCH1:   next_state = S_FETCHW;
            S_FETCHW:   next_state = wait_done ? S_FETCH3 : S_FETCHW;
            S_FETCH3:   next_state = S_DECODE;
            S_DECODE: begin
                case (OPCODE)
                    6'h00: begin
                        case (FUNCT)
                            6'h20, 6'h22, 6'h24: next_state = S_R_EX;
                            6'h18:               next_state = S_MULT;
                            6'h10, 6'h12:        next_state = S_MFHL;
                            default:             next_state = S_EXC1;
                        endcase
                    end
                    6'h08:        next_state = S_ADDI_EX;
                    6'h23, 6'h2B: next_state = S_ADDR;
                    6'h04, 6'h05: next_state = S_BR;
                    6'h02:        next_state = S_JUMP;
                    default:      next_state = S_EXC1;
                endcase
            end
            // and cannot overflow, so only add/sub trap
            S_R_EX:     next_state = (OVERFLOW && FUNCT != 6'h24) ? S_EXC1 : S_R_WB;
            S_R_WB:     next_state = S_FETCH1;
            S_ADDI_EX:  next_state = OVERFLOW ? S_EXC1 : S_ADDI_WB;
            S_ADDI_WB:  next_state = S_FETCH1;
            S_MULT:     next_state = S_MULT_W;
            S_MULT_W:   next_state = mult_end ? S_MULT_END : S_MULT_W;
            S_MULT_END: next_state = S_FETCH1;
            S_MFHL:     next_state = S_FETCH1;
            S_ADDR:     next_state = (OPCODE == 6'h2B) ? S_SW : S_LD1;
            S_SW:       next_state = S_FETCH1;
            S_LD1:      next_state = S_LDW;
            S_LDW:      next_state = wait_done ? S_LD3 : S_LDW;
            S_LD3:      next_state = S_LD_WB;
            S_LD_WB:    next_state = S_FETCH1;
            S_BR:       next_state = S_FETCH1;
            S_JUMP:     next_state = S_FETCH1;
            S_EXC1:     next_state = S_EXC2;
            S_EXC2:     next_state = S_EXCW;
            S_EXCW:     next_state = wait_done ? S_EXC4 : S_EXCW;
            S_EXC4:     next_state = S_FETCH1;
            default:    next_state = S_RESET;
        endcase
    end

    // Output logic
    always_comb begin
        PC_w = 1'b0; PC_w_cond = 1'b0; EPC_w = 1'b0; MEM_w = 1'b0; IR_w = 1'b0;
        ALUOut_w = 1'b0; RB_w = 1'b0; A_w = 1'b0; B_w = 1'b0; HI_w = 1'b0; LO_w = 1'b0;
        MEM_DATA_REG_w = 1'b0; mult_control = 1'b0;
        Mux_PC = 2'd0; Mux_MEM = 2'd0; Mux_EXC = 2'd0; Mux_W_RB = 2'd0; Mux_W_DT = 3'd0;
        Mux_ALUSrcA = 2'd0; Mux_ALUSrcB = 2'd0; ALUOp = 4'd0;
        LS_control = 2'd0; SS_control = 2'd0;
        case (state)
            S_FETCH1:   begin Mux_ALUSrcB = 2'd1; ALUOp = 4'd1; ALUOut_w = 1'b1; end
            S_FETCHW:   begin Mux_ALUSrcB = 2'd1; ALUOp = 4'd1; end
            S_FETCH3:   begin IR_w = 1'b1; Mux_PC = 2'd1; PC_w = 1'b1; end
            S_DECODE:   begin A_w = 1'b1; B_w = 1'b1; Mux_ALUSrcB = 2'd3; ALUOp = 4'd1;
                              ALUOut_w = 1'b1; end
            S_R_EX:     begin Mux_ALUSrcA = 2'd1; ALUOp = r_alu_op; end
            S_R_WB:     begin Mux_ALUSrcA = 2'd1; ALUOp = r_alu_op; Mux_W_RB = 2'd1;
                              RB_w = 1'b1; end
            S_ADDI_EX:  begin Mux_ALUSrcA = 2'd1; Mux_ALUSrcB = 2'd2; ALUOp = 4'd1; end
            S_ADDI_WB:  begin Mux_ALUSrcA = 2'd1; Mux_ALUSrcB = 2'd2; ALUOp = 4'd1;
                              RB_w = 1'b1; end
            S_MULT:     mult_control = 1'b1;
            S_MULT_END: begin HI_w = 1'b1; LO_w = 1'b1; end
            S_MFHL:     begin RB_w = 1'b1; Mux_W_RB = 2'd1;
                              Mux_W_DT = (FUNCT == 6'h10) ? 3'd3 : 3'd4; end
            S_ADDR:     begin Mux_ALUSrcA = 2'd1; Mux_ALUSrcB = 2'd2; ALUOp = 4'd1;
                              ALUOut_w = 1'b1; end
            S_SW:       begin Mux_MEM = 2'd1; MEM_w = 1'b1; end
            S_LD1,
            S_LDW:      Mux_MEM = 2'd1;
            S_LD3:      begin Mux_MEM = 2'd1; MEM_DATA_REG_w = 1'b1; end
            S_LD_WB:    begin Mux_W_DT = 3'd1; RB_w = 1'b1; end
            // PC_w here is the one Mealy output: the branch resolves on the live ZERO flag
            S_BR:       begin Mux_ALUSrcA = 2'd1; ALUOp = 4'd2; Mux_PC = 2'd1;
                              PC_w = (OPCODE == 6'h04) ? ZERO : ~ZERO; end
            S_JUMP:     begin Mux_PC = 2'd2; PC_w = 1'b1; end
            S_EXC1:     begin Mux_ALUSrcB = 2'd1; ALUOp = 4'd2; ALUOut_w = 1'b1; end
            S_EXC2:     begin EPC_w = 1'b1; Mux_MEM = 2'd3; Mux_EXC = exc_code; end
            S_EXCW:     begin Mux_MEM = 2'd3; Mux_EXC = exc_code; end
            S_EXC4:     begin Mux_MEM = 2'd3; Mux_ALUSrcA = 2'd2; PC_w = 1'b1; end
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver issues instructions and
// pushes the per-cycle output trace the instruction must produce; a monitor
// on the falling edge pops and compares one entry per cycle.
module tb_control_unit;

    localparam int MW = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OPCODE, FUNCT;
    logic       OVERFLOW, ZERO, mult_end;
    logic       PC_w, PC_w_cond, EPC_w, MEM_w, IR_w, ALUOut_w, RB_w, A_w, B_w, HI_w, LO_w;
    logic       MEM_DATA_REG_w, mult_control;
    logic [1:0] Mux_PC, Mux_MEM, Mux_EXC, Mux_W_RB, Mux_ALUSrcA, Mux_ALUSrcB;
    logic [2:0] Mux_W_DT;
    logic [3:0] ALUOp;
    logic [1:0] LS_control, SS_control;
    logic [5:0] state;

    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT(MW), .EXC_OP_SEL(2'd0), .EXC_OVF_SEL(2'd1)) dut (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .OVERFLOW(OVERFLOW),
        .ZERO(ZERO), .mult_end(mult_end), .PC_w(PC_w), .PC_w_cond(PC_w_cond),
        .EPC_w(EPC_w), .MEM_w(MEM_w), .IR_w(IR_w), .ALUOut_w(ALUOut_w), .RB_w(RB_w),
        .A_w(A_w), .B_w(B_w), .HI_w(HI_w), .LO_w(LO_w), .MEM_DATA_REG_w(MEM_DATA_REG_w),
        .mult_control(mult_control), .Mux_PC(Mux_PC), .Mux_MEM(Mux_MEM), .Mux_EXC(Mux_EXC),
        .Mux_W_RB(Mux_W_RB), .Mux_W_DT(Mux_W_DT), .Mux_ALUSrcA(Mux_ALUSrcA),
        .Mux_ALUSrcB(Mux_ALUSrcB), .ALUOp(ALUOp), .LS_control(LS_control),
        .SS_control(SS_control), .state(state)
    );

    typedef struct packed {
        logic pc_w, pc_w_cond, epc_w, mem_w, ir_w, aluout_w, rb_w, a_w, b_w, hi_w, lo_w;
        logic mdr_w, mult_control;
        logic [1:0] mux_pc, mux_mem, mux_exc, mux_w_rb;
        logic [2:0] mux_w_dt;
        logic [1:0] srca, srcb;
        logic [3:0] aluop;
        logic [1:0] ls, ss;
    } ov_t;

    ov_t act;
    assign act = {PC_w, PC_w_cond, EPC_w, MEM_w, IR_w, ALUOut_w, RB_w, A_w, B_w, HI_w, LO_w,
                  MEM_DATA_REG_w, mult_control, Mux_PC, Mux_MEM, Mux_EXC, Mux_W_RB, Mux_W_DT,
                  Mux_ALUSrcA, Mux_ALUSrcB, ALUOp, LS_control, SS_control};

    ov_t q[$];
    int  total = 0, passed = 0;
    string cur_name = "init";

    // Monitor: one expected output vector per clock cycle while a trace is pending
    always @(negedge clk) begin
        if (q.size() > 0) begin
            ov_t e;
            e = q.pop_front();
            total++;
            if (act !== e)
                $display("FAIL %s cycle-vector: got %h want %h (left %0d)",
                         cur_name, act, e, q.size());
            else
                passed++;
        end
    end

    // Reference model: output trace of one instruction, from the instruction rules
    task automatic push_exc(input logic [1:0] code);
        ov_t o;
        o = '0; o.srcb = 2'd1; o.aluop = 4'd2; o.aluout_w = 1'b1; q.push_back(o);
        o = '0; o.epc_w = 1'b1; o.mux_mem = 2'd3; o.mux_exc = code; q.push_back(o);
        for (int i = 0; i < MW; i++) begin
            o = '0; o.mux_mem = 2'd3; o.mux_exc = code; q.push_back(o);
        end
        o = '0; o.mux_mem = 2'd3; o.srca = 2'd2; o.pc_w = 1'b1; q.push_back(o);
    endtask

    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                         input logic zr, input int k);
        ov_t o;
        logic [3:0] alu;
        o = '0; o.srcb = 2'd1; o.aluop = 4'd1; o.aluout_w = 1'b1; q.push_back(o);
        for (int i = 0; i < MW; i++) begin
            o = '0; o.srcb = 2'd1; o.aluop = 4'd1; q.push_back(o);
        end
        o = '0; o.ir_w = 1'b1; o.mux_pc = 2'd1; o.pc_w = 1'b1; q.push_back(o);
        o = '0; o.a_w = 1'b1; o.b_w = 1'b1; o.srcb = 2'd3; o.aluop = 4'd1; o.aluout_w = 1'b1;
        q.push_back(o);
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) begin
                alu = (fn == 6'h20) ? 4'd1 : (fn == 6'h22) ? 4'd2 : 4'd3;
                o = '0; o.srca = 2'd1; o.aluop = alu; q.push_back(o);
                if (ovf && fn != 6'h24) push_exc(2'd1);
                else begin o.rb_w = 1'b1; o.mux_w_rb = 2'd1; q.push_back(o); end
            end else if (fn == 6'h18) begin
                o = '0; o.mult_control = 1'b1; q.push_back(o);
                for (int i = 0; i < k; i++) begin o = '0; q.push_back(o); end
                o = '0; o.hi_w = 1'b1; o.lo_w = 1'b1; q.push_back(o);
            end else if (fn == 6'h10 || fn == 6'h12) begin
                o = '0; o.rb_w = 1'b1; o.mux_w_rb = 2'd1;
                o.mux_w_dt = (fn == 6'h10) ? 3'd3 : 3'd4; q.push_back(o);
            end else push_exc(2'd0);
        end else if (op == 6'h08) begin
            o = '0; o.srca = 2'd1; o.srcb = 2'd2; o.aluop = 4'd1; q.push_back(o);
            if (ovf) push_exc(2'd1);
            else begin o.rb_w = 1'b1; q.push_back(o); end
        end else if (op == 6'h23 || op == 6'h2B) begin
            o = '0; o.srca = 2'd1; o.srcb = 2'd2; o.aluop = 4'd1; o.aluout_w = 1'b1;
            q.push_back(o);
            if (op == 6'h2B) begin
                o = '0; o.mux_mem = 2'd1; o.mem_w = 1'b1; q.push_back(o);
            end else begin
                for (int i = 0; i < MW + 1; i++) begin o = '0; o.mux_mem = 2'd1; q.push_back(o); end
                o = '0; o.mux_mem = 2'd1; o.mdr_w = 1'b1; q.push_back(o);
                o = '0; o.mux_w_dt = 3'd1; o.rb_w = 1'b1; q.push_back(o);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            o = '0; o.srca = 2'd1; o.aluop = 4'd2; o.mux_pc = 2'd1;
            o.pc_w = (op == 6'h04) ? zr : !zr; q.push_back(o);
        end else if (op == 6'h02) begin
            o = '0; o.mux_pc = 2'd2; o.pc_w = 1'b1; q.push_back(o);
        end else push_exc(2'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin @(posedge clk); n++; end
        if (q.size() != 0) begin
            total++;
            $display("FAIL %s drain-timeout: got %0d entries left want 0", cur_name, q.size());
            q.delete();
        end
        #1;
    endtask

    // Called 1 time unit after the edge that starts FETCH1
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic ovf, input logic zr, input int k);
        cur_name = name;
        OPCODE = op; FUNCT = fn; OVERFLOW = ovf; ZERO = zr; mult_end = 1'b0;
        model(op, fn, ovf, zr, k);
        if (op == 6'h00 && fn == 6'h18) begin
            repeat (3 + MW + k) @(posedge clk);
            #1 mult_end = 1'b1;
            @(posedge clk);
            #1 mult_end = 1'b0;
        end
        drain();
    endtask

    task automatic check_reset(input string name);
        total++;
        if (act !== '0 || state !== 6'd0)
            $display("FAIL %s: got outputs %h state %0d want 0 state 0", name, act, state);
        else
            passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
        logic [5:0] fns [7]  = '{6'h20, 6'h22, 6'h24, 6'h18, 6'h10, 6'h12, 6'h00};
        logic [5:0] rop, rfn;
        reset = 1'b1; OPCODE = '0; FUNCT = '0; OVERFLOW = 1'b0; ZERO = 1'b0; mult_end = 1'b0;
        @(negedge clk);
        check_reset("reset_hold");
        @(negedge clk);
        check_reset("reset_hold2");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        run("addi",        6'h08, 6'h00, 1'b0, 1'b0, 0);
        run("lw",          6'h23, 6'h00, 1'b0, 1'b0, 0);
        run("beq_z1",      6'h04, 6'h00, 1'b0, 1'b1, 0);
        run("beq_z0",      6'h04, 6'h00, 1'b0, 1'b0, 0);
        run("bne_z1",      6'h05, 6'h00, 1'b0, 1'b1, 0);
        run("bne_z0",      6'h05, 6'h00, 1'b0, 1'b0, 0);
        run("mult_long",   6'h00, 6'h18, 1'b0, 1'b0, 34);
        run("add_ovf",     6'h00, 6'h20, 1'b1, 1'b0, 0);
        run("sub_ovf",     6'h00, 6'h22, 1'b1, 1'b0, 0);
        run("and_ovf",     6'h00, 6'h24, 1'b1, 1'b0, 0);
        run("bad_op",      6'h3F, 6'h00, 1'b0, 1'b0, 0);
        run("addi_ovf",    6'h08, 6'h00, 1'b1, 1'b0, 0);
        run("sw",          6'h2B, 6'h00, 1'b0, 1'b0, 0);
        run("j",           6'h02, 6'h00, 1'b0, 1'b0, 0);
        run("mfhi",        6'h00, 6'h10, 1'b0, 1'b0, 0);
        run("mflo",        6'h00, 6'h12, 1'b0, 1'b0, 0);
        run("bad_funct",   6'h00, 6'h3F, 1'b0, 1'b0, 0);
        run("add",         6'h00, 6'h20, 1'b0, 1'b0, 0);
        run("mult_short",  6'h00, 6'h18, 1'b0, 1'b0, 1);

        // Reset asserted while waiting in MULT_W, away from any clock edge
        cur_name = "mult_reset";
        OPCODE = 6'h00; FUNCT = 6'h18; OVERFLOW = 1'b0; ZERO = 1'b0; mult_end = 1'b0;
        model(6'h00, 6'h18, 1'b0, 1'b0, 50);
        repeat (3 + MW + 3) @(posedge clk);
        #2 reset = 1'b1;
        q.delete();
        #1 check_reset("reset_async_in_mult_w");
        @(posedge clk); #1 check_reset("reset_hold_after_async");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        run("add_after_reset", 6'h00, 6'h22, 1'b0, 1'b0, 0);

        for (int i = 0; i < 80; i++) begin
            rop = ops[$urandom_range(0, 9)];
            rfn = fns[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) rop = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) rfn = 6'($urandom_range(0, 63));
            run($sformatf("rand%0d_op%h_fn%h", i, rop, rfn), rop, rfn,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 6));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
